// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: hold enables and bubble
// controls for PC, IF/ID, ID/EX, EX/MEM, MEM/WB, plus perf counters and a D-memory watchdog.
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES  = 5,
  parameter int DMEM_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_USES_RS1,
  input  logic             ID_USES_RS2,
  input  logic [4:0]       EX_RD,
  input  logic             EX_MEM_READ,
  input  logic             BRANCH_TAKEN,
  input  logic             IMEM_BUSY,
  input  logic             DMEM_BUSY,
  output logic             PC_WRITE_EN,
  output logic             PC_SEL_TARGET,
  output logic             IF_ID_EN,
  output logic             ID_EX_EN,
  output logic             EX_MEM_EN,
  output logic             MEM_WB_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             EX_MEM_FLUSH,
  output logic             MEM_WB_FLUSH,
  output logic [CNT_W-1:0] STALL_COUNT,
  output logic [CNT_W-1:0] FLUSH_COUNT,
  output logic             DMEM_TIMEOUT_ERR,
  output logic [1:0]       DBG_STATE
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWAIT = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [3:0]  INIT_LAST  = 4'(INIT_CYCLES - 1);
  localparam logic [16:0] WD_LIMIT   = 17'(DMEM_TIMEOUT);

  state_t      state;
  logic [3:0]  init_cnt;
  logic [15:0] wd_cnt;
  logic [16:0] wd_inc;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        load_use;
  logic        active;
  logic        stall_event;
  logic        branch_event;

  assign DBG_STATE = state;

  // Load-use: the load's result is not available until after MEM, so a
  // dependent instruction in ID must wait one cycle. x0 never creates a hazard.
  assign rs1_hit  = ID_USES_RS1 && (ID_RS1 == EX_RD);
  assign rs2_hit  = ID_USES_RS2 && (ID_RS2 == EX_RD);
  assign load_use = EX_MEM_READ && (EX_RD != 5'd0) && (rs1_hit || rs2_hit);

  assign active = (state == ST_RUN) || (state == ST_DWAIT);
  assign wd_inc = {1'b0, wd_cnt} + 17'd1;

  always_comb begin
    PC_WRITE_EN   = 1'b0;
    PC_SEL_TARGET = 1'b0;
    IF_ID_EN      = 1'b0;
    ID_EX_EN      = 1'b0;
    EX_MEM_EN     = 1'b0;
    MEM_WB_EN     = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_FLUSH   = 1'b0;
    EX_MEM_FLUSH  = 1'b0;
    MEM_WB_FLUSH  = 1'b0;
    if (!RESET) begin
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      EX_MEM_FLUSH = 1'b1;
      MEM_WB_FLUSH = 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          IF_ID_EN     = 1'b1;
          ID_EX_EN     = 1'b1;
          EX_MEM_EN    = 1'b1;
          MEM_WB_EN    = 1'b1;
          IF_ID_FLUSH  = 1'b1;
          ID_EX_FLUSH  = 1'b1;
          EX_MEM_FLUSH = 1'b1;
          MEM_WB_FLUSH = 1'b1;
        end
        ST_RUN, ST_DWAIT: begin
          if (DMEM_BUSY) begin
            // Full freeze: everything holds, including any branch sitting in EX.
            PC_WRITE_EN = 1'b0;
          end else if (BRANCH_TAKEN) begin
            PC_WRITE_EN   = 1'b1;
            PC_SEL_TARGET = 1'b1;
            IF_ID_EN      = 1'b1;
            ID_EX_EN      = 1'b1;
            EX_MEM_EN     = 1'b1;
            MEM_WB_EN     = 1'b1;
            IF_ID_FLUSH   = 1'b1;
            ID_EX_FLUSH   = 1'b1;
          end else if (load_use) begin
            ID_EX_EN    = 1'b1;
            EX_MEM_EN   = 1'b1;
            MEM_WB_EN   = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end else if (IMEM_BUSY) begin
            IF_ID_EN    = 1'b1;
            ID_EX_EN    = 1'b1;
            EX_MEM_EN   = 1'b1;
            MEM_WB_EN   = 1'b1;
            IF_ID_FLUSH = 1'b1;
          end else begin
            PC_WRITE_EN = 1'b1;
            IF_ID_EN    = 1'b1;
            ID_EX_EN    = 1'b1;
            EX_MEM_EN   = 1'b1;
            MEM_WB_EN   = 1'b1;
          end
        end
        default: begin
          PC_WRITE_EN = 1'b0;
        end
      endcase
    end
  end

  assign stall_event  = active && (!PC_WRITE_EN || IF_ID_FLUSH || ID_EX_FLUSH ||
                                   EX_MEM_FLUSH || MEM_WB_FLUSH);
  assign branch_event = active && !DMEM_BUSY && BRANCH_TAKEN;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state            <= ST_INIT;
      init_cnt         <= 4'd0;
      wd_cnt           <= 16'd0;
      STALL_COUNT      <= '0;
      FLUSH_COUNT      <= '0;
      DMEM_TIMEOUT_ERR <= 1'b0;
    end else begin
      if (stall_event) STALL_COUNT <= STALL_COUNT + 1'b1;
      if (branch_event) FLUSH_COUNT <= FLUSH_COUNT + 1'b1;
      case (state)
        ST_INIT: begin
          if (init_cnt == INIT_LAST) state <= ST_RUN;
          else init_cnt <= init_cnt + 4'd1;
        end
        ST_RUN, ST_DWAIT: begin
          if (DMEM_BUSY) begin
            wd_cnt <= wd_inc[15:0];
            if (wd_inc >= WD_LIMIT) begin
              state            <= ST_ERROR;
              DMEM_TIMEOUT_ERR <= 1'b1;
            end else begin
              state <= ST_DWAIT;
            end
          end else begin
            state  <= ST_RUN;
            wd_cnt <= 16'd0;
          end
        end
        default: begin
          // Only a reset leaves the error state.
          state            <= ST_ERROR;
          DMEM_TIMEOUT_ERR <= 1'b1;
        end
      endcase
    end
  end

endmodule
